lcd_timing: RTL
===============

LCD_TIMING -- requirements
Module: lcd_timing

Interface
REQ-001 Parameter DOTS_PER_LINE, default 456, clocks per scanline.
REQ-002 Parameter LINES_PER_FRAME, default 154, scanlines per frame (LY 0..153).
REQ-003 Parameter VISIBLE_LINES, default 144, lines rendered (LY 0..143).
REQ-004 Parameter OAM_DOTS, default 80, mode-2 length in dots.
REQ-005 Parameter DRAW_DOTS, default 172, mode-3 length in dots.
REQ-006 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 Port reset_n  input  1  reset; one clock, synchronous, active-low reset.
REQ-008 Port lcd_enable  input  1  LCDC bit 7; 0 holds timing idle.
REQ-009 Port addr  input  16  CPU bus address.
REQ-010 Port data_in  input  8  CPU write data.
REQ-011 Port rd  input  1  bus read strobe, one cycle.
REQ-012 Port wr  input  1  bus write strobe, one cycle.
REQ-013 Port data_out  output  8  registered read data.
REQ-014 Port data_oe  output  1  high when data_out drives the bus.
REQ-015 Port drawline  output  1  one-cycle pulse requesting render of line LY.
REQ-016 Port ly  output  8  current scanline.
REQ-017 Port mode  output  2  PPU mode (0 HBlank, 1 VBlank, 2 OAM, 3 draw).
REQ-018 Port vblank_irq  output  1  one-cycle VBlank interrupt request.
REQ-019 Port stat_irq  output  1  one-cycle STAT interrupt request.

Function
REQ-020 Dot counter 0..DOTS_PER_LINE-1 increments each clk while lcd_enable=1; at DOTS_PER_LINE-1 wraps to 0 and LY increments.
REQ-021 LY wraps LINES_PER_FRAME-1 -> 0 at end of line 153.
REQ-022 Mode, LY < VISIBLE_LINES: 2 for dot 0..OAM_DOTS-1; 3 for OAM_DOTS..OAM_DOTS+DRAW_DOTS-1; 0 otherwise.
REQ-023 Mode = 1 for all dots when LY >= VISIBLE_LINES.
REQ-024 mode and ly outputs are registered; they reflect the counter state in the same cycle as dot/LY (no extra latency).
REQ-025 drawline high exactly one cycle, the cycle mode first equals 3 on a visible line; never in VBlank; ly valid and stable while high.
REQ-026 vblank_irq high one cycle when LY becomes VISIBLE_LINES at dot 0.
REQ-027 Coincidence flag = (LY == LYC), updated every cycle.
REQ-028 STAT line = (STAT[6] & coincidence) | (STAT[5] & mode==2) | (STAT[4] & mode==1) | (STAT[3] & mode==0); stat_irq pulses one cycle on its 0->1 edge only.
REQ-029 Register FF41 STAT: read = {1, ie[6:3], coincidence, mode[1:0]}; writes update bits 6:3 only.
REQ-030 Register FF44 LY: read-only; writes ignored.
REQ-031 Register FF45 LYC: read/write 8 bits; new value affects coincidence from next cycle.
REQ-032 Read: rd with addr in {FF41, FF44, FF45} -> next cycle data_out = value, data_oe = 1 for one cycle; other addresses -> data_oe = 0.
REQ-033 Write takes effect on the clk edge where wr=1; rd and wr together -> write wins, data_oe = 0.
REQ-034 lcd_enable=0: dot=0, LY=0, mode=0, drawline/vblank_irq/stat_irq=0; registers remain accessible; STAT line edge detector cleared.
REQ-035 lcd_enable 0->1: counting starts at dot 0, LY 0, mode 2 in the first enabled cycle.
REQ-036 lcd_enable dropping mid-line aborts immediately; no drawline or irq that cycle.

Reset
REQ-037 reset_n=0 at clk edge: dot=0, LY=0, mode=0, LYC=0, STAT ie=0, data_out=0, data_oe=0, drawline=0, vblank_irq=0, stat_irq=0.
REQ-038 Reset takes priority over lcd_enable, rd and wr; reset mid-line discards the line with no pulses.

Verification
REQ-039 Enable after reset, run 456x154 cycles -> exactly 144 drawline pulses, first at cycle 80, LY 0..143 in order; one vblank_irq at cycle 144x456.
REQ-040 Sample mode on line 5 -> 2 at dots 0-79, 3 at 80-251, 0 at 252-455; line 150 -> 1 throughout.
REQ-041 Write LYC=0x0A, STAT=0x40 -> stat_irq single pulse at LY=10 dot 0; read FF41 then returns 0xC6.
REQ-042 STAT=0x08 (HBlank ie) -> one stat_irq per visible line at dot 252, none in VBlank.
REQ-043 Write FF44=0x55 then read -> current LY, not 0x55; read FF00 -> data_oe=0.
REQ-044 Drop lcd_enable at LY=3 dot 100, re-enable -> ly=0, mode=2, next drawline 80 cycles later for LY 0.

Source files
------------

// File: rtl/lcd_timing.sv
// Scanline/frame timing for an LCD controller: dot and line counters, PPU mode,
// render/interrupt pulses, and the STAT/LY/LYC bus registers.
module lcd_timing #(
   parameter int DOTS_PER_LINE   = 456,
   parameter int LINES_PER_FRAME = 154,
   parameter int VISIBLE_LINES   = 144,
   parameter int OAM_DOTS        = 80,
   parameter int DRAW_DOTS       = 172
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        lcd_enable,
   input  logic [15:0] addr,
   input  logic [7:0]  data_in,
   input  logic        rd,
   input  logic        wr,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        drawline,
   output logic [7:0]  ly,
   output logic [1:0]  mode,
   output logic        vblank_irq,
   output logic        stat_irq
);

   localparam int DOT_W = (DOTS_PER_LINE > 1) ? $clog2(DOTS_PER_LINE) : 1;

   localparam logic [DOT_W-1:0] DOT_LAST   = DOT_W'(DOTS_PER_LINE - 1);
   localparam logic [DOT_W-1:0] DRAW_START = DOT_W'(OAM_DOTS);
   localparam logic [DOT_W-1:0] DRAW_END   = DOT_W'(OAM_DOTS + DRAW_DOTS);
   localparam logic [7:0]       LY_LAST    = 8'(LINES_PER_FRAME - 1);
   localparam logic [7:0]       LY_VBL     = 8'(VISIBLE_LINES);

   localparam logic [15:0] ADDR_STAT = 16'hFF41;
   localparam logic [15:0] ADDR_LY   = 16'hFF44;
   localparam logic [15:0] ADDR_LYC  = 16'hFF45;

   localparam logic [1:0] MODE_HBLANK = 2'd0;
   localparam logic [1:0] MODE_VBLANK = 2'd1;
   localparam logic [1:0] MODE_OAM    = 2'd2;
   localparam logic [1:0] MODE_DRAW   = 2'd3;

   // Registered state (stage 1)
   logic [DOT_W-1:0] dot_p1;
   logic [7:0]       ly_p1;
   logic [1:0]       mode_p1;
   logic             run_p1;
   logic [7:0]       lyc_p1;
   logic [3:0]       ie_p1;
   logic             line_p1;
   logic             draw_p1;
   logic             vbl_p1;
   logic             sirq_p1;
   logic [7:0]       dout_p1;
   logic             doe_p1;

   // Next-state values (stage 0)
   logic [DOT_W-1:0] dot_p0;
   logic [7:0]       ly_p0;
   logic [1:0]       mode_p0;
   logic [7:0]       lyc_p0;
   logic [3:0]       ie_p0;
   logic             line_p0;
   logic             draw_p0;
   logic             vbl_p0;
   logic             rd_hit;
   logic             coin;
   logic [7:0]       rd_val;

   function automatic logic [1:0] mode_of(input logic [DOT_W-1:0] d, input logic [7:0] l);
      logic [1:0] m;
      if (l >= LY_VBL)
         m = MODE_VBLANK;
      else if (d < DRAW_START)
         m = MODE_OAM;
      else if (d < DRAW_END)
         m = MODE_DRAW;
      else
         m = MODE_HBLANK;
      return m;
   endfunction

   assign coin = (ly_p1 == lyc_p1);

   always_comb begin
      dot_p0  = '0;
      ly_p0   = '0;
      mode_p0 = MODE_HBLANK;
      draw_p0 = 1'b0;
      vbl_p0  = 1'b0;
      line_p0 = 1'b0;
      lyc_p0  = lyc_p1;
      ie_p0   = ie_p1;

      if (wr && (addr == ADDR_LYC))
         lyc_p0 = data_in;
      if (wr && (addr == ADDR_STAT))
         ie_p0 = data_in[6:3];

      // The first enabled cycle holds dot 0 / line 0 so it presents as mode 2.
      if (lcd_enable) begin
         if (run_p1) begin
            if (dot_p1 == DOT_LAST) begin
               dot_p0 = '0;
               ly_p0  = (ly_p1 == LY_LAST) ? 8'd0 : ly_p1 + 8'd1;
            end else begin
               dot_p0 = dot_p1 + 1'b1;
               ly_p0  = ly_p1;
            end
         end
         mode_p0 = mode_of(dot_p0, ly_p0);
         draw_p0 = (ly_p0 < LY_VBL) && (dot_p0 == DRAW_START);
         vbl_p0  = (ly_p0 == LY_VBL) && (dot_p0 == '0);
         line_p0 = (ie_p0[3] && (ly_p0 == lyc_p0))
                 | (ie_p0[2] && (mode_p0 == MODE_OAM))
                 | (ie_p0[1] && (mode_p0 == MODE_VBLANK))
                 | (ie_p0[0] && (mode_p0 == MODE_HBLANK));
      end
   end

   always_comb begin
      rd_hit = 1'b0;
      rd_val = 8'h00;
      case (addr)
         ADDR_STAT: begin
            rd_hit = 1'b1;
            rd_val = {1'b1, ie_p1, coin, mode_p1};
         end
         ADDR_LY: begin
            rd_hit = 1'b1;
            rd_val = ly_p1;
         end
         ADDR_LYC: begin
            rd_hit = 1'b1;
            rd_val = lyc_p1;
         end
         default: begin
            rd_hit = 1'b0;
            rd_val = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dot_p1  <= '0;
         ly_p1   <= '0;
         mode_p1 <= MODE_HBLANK;
         run_p1  <= 1'b0;
         lyc_p1  <= '0;
         ie_p1   <= '0;
         line_p1 <= 1'b0;
         draw_p1 <= 1'b0;
         vbl_p1  <= 1'b0;
         sirq_p1 <= 1'b0;
         dout_p1 <= '0;
         doe_p1  <= 1'b0;
      end else begin
         dot_p1  <= dot_p0;
         ly_p1   <= ly_p0;
         mode_p1 <= mode_p0;
         run_p1  <= lcd_enable;
         lyc_p1  <= lyc_p0;
         ie_p1   <= ie_p0;
         line_p1 <= line_p0;
         draw_p1 <= draw_p0;
         vbl_p1  <= vbl_p0;
         sirq_p1 <= line_p0 & ~line_p1;
         doe_p1  <= rd & ~wr & rd_hit;
         if (rd && !wr && rd_hit)
            dout_p1 <= rd_val;
      end
   end

   assign ly         = ly_p1;
   assign mode       = mode_p1;
   assign drawline   = draw_p1;
   assign vblank_irq = vbl_p1;
   assign stat_irq   = sirq_p1;
   assign data_out   = dout_p1;
   assign data_oe    = doe_p1;

endmodule
